// File: rtl/juggle_pkg.sv
// Shared constants, enums and helpers for the siteswap validator and the
// trajectory generator that consumes its validated patterns.
package juggle_pkg;

  localparam int MAX_PERIOD = 7;
  localparam int DIGIT_W    = 3;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_EMPTY      = 3'd1,
    ERR_COLLISION  = 3'd2,
    ERR_OVERFLOW   = 3'd3,
    ERR_ZERO_BALLS = 3'd4
  } err_e;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DIV
  } state_e;

  // Small modulo used for landing slots and the periodic fill; a zero divisor
  // only occurs when nothing is buffered and its result is then unused.
  function automatic logic [2:0] mod_small(input logic [3:0] a, input logic [2:0] n);
    return (n == 3'd0) ? 3'd0 : 3'(a % {1'b0, n});
  endfunction

endpackage

// File: rtl/siteswap_validator_if.sv
// Digit-entry and validated-pattern bundle between the UI side and the
// siteswap validator. The validator takes the slave view.
interface siteswap_validator_if;
  import juggle_pkg::*;

  logic [DIGIT_W-1:0] digit_in;
  logic               digit_valid_in;
  logic               clear_in;
  logic               commit_in;

  logic [DIGIT_W-1:0] pattern_out [MAX_PERIOD-1:0];
  logic [2:0]         period_out;
  logic [2:0]         num_balls_out;
  logic               pattern_valid_out;
  logic [2:0]         error_out;
  logic               busy_out;

  modport slave (
    input  digit_in, digit_valid_in, clear_in, commit_in,
    output pattern_out, period_out, num_balls_out, pattern_valid_out, error_out, busy_out
  );

  modport master (
    output digit_in, digit_valid_in, clear_in, commit_in,
    input  pattern_out, period_out, num_balls_out, pattern_valid_out, error_out, busy_out
  );

endinterface

// File: rtl/siteswap_validator.sv
// Siteswap entry buffer and validator. Digits are appended one per strobe;
// a commit walks the buffer one digit per cycle checking that no two throws
// land in the same beat, then divides the throw sum by the period by repeated
// subtraction to get the ball count. A good pattern is published with a
// one-cycle pattern_valid pulse and held through later errors.
// Optional build macro SITESWAP_DEFAULT_EN: reset loads the 3-ball cascade
// and pulses pattern_valid once after reset so the display starts animating.
module siteswap_validator
  import juggle_pkg::*;
(
  input logic             clk_in,
  input logic             rst_in,
  siteswap_validator_if.slave bus
);

`ifdef SITESWAP_DEFAULT_EN
  localparam logic [DIGIT_W-1:0] RESET_DIGIT  = 3'd3;
  localparam logic [2:0]         RESET_PERIOD = 3'd1;
  localparam logic [2:0]         RESET_BALLS  = 3'd3;
`else
  localparam logic [DIGIT_W-1:0] RESET_DIGIT  = 3'd0;
  localparam logic [2:0]         RESET_PERIOD = 3'd0;
  localparam logic [2:0]         RESET_BALLS  = 3'd0;
`endif

  state_e             state_q, state_d;
  logic [DIGIT_W-1:0] digit_buf_q [MAX_PERIOD-1:0];
  logic [DIGIT_W-1:0] digit_buf_d [MAX_PERIOD-1:0];
  logic [2:0]         len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [2:0]         idx_q, idx_d;
  logic [5:0]         sum_q, sum_d;
  logic [MAX_PERIOD-1:0] mask_q, mask_d;
  logic [5:0]         rem_q, rem_d;
  logic [2:0]         quot_q, quot_d;
  err_e               error_q, error_d;
  logic [DIGIT_W-1:0] pattern_q [MAX_PERIOD-1:0];
  logic [DIGIT_W-1:0] pattern_d [MAX_PERIOD-1:0];
  logic [2:0]         period_q, period_d;
  logic [2:0]         balls_q, balls_d;
  logic               valid_q, valid_d;
`ifdef SITESWAP_DEFAULT_EN
  logic               boot_q;
`endif

  logic [DIGIT_W-1:0] digit_cur;
  logic [2:0]         land;
  logic [5:0]         sum_next;

  // Next-state and datapath updates; clear overrides every state.
  always_comb begin
    state_d     = state_q;
    digit_buf_d = digit_buf_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    mask_d      = mask_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    error_d     = error_q;
    pattern_d   = pattern_q;
    period_d    = period_q;
    balls_d     = balls_q;
    valid_d     = 1'b0;

    digit_cur = digit_buf_q[idx_q];
    land      = mod_small({1'b0, idx_q} + {1'b0, digit_cur}, len_q);
    sum_next  = sum_q + {3'b000, digit_cur};

    if (bus.clear_in) begin
      state_d = IDLE;
      len_d   = 3'd0;
      ovf_d   = 1'b0;
      error_d = ERR_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.commit_in) begin
            error_d = ERR_NONE;
            if (len_q == 3'd0) begin
              error_d = ERR_EMPTY;
            end else if (ovf_q) begin
              error_d = ERR_OVERFLOW;
            end else begin
              idx_d   = 3'd0;
              sum_d   = 6'd0;
              mask_d  = '0;
              state_d = CHECK;
            end
          end else if (bus.digit_valid_in) begin
            if (len_q < 3'(MAX_PERIOD)) begin
              digit_buf_d[len_q] = bus.digit_in;
              len_d              = len_q + 3'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end

        CHECK: begin
          if (mask_q[land]) begin
            error_d = ERR_COLLISION;
            state_d = IDLE;
          end else begin
            mask_d[land] = 1'b1;
            sum_d        = sum_next;
            if (idx_q == len_q - 3'd1) begin
              rem_d   = sum_next;
              quot_d  = 3'd0;
              state_d = DIV;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end

        DIV: begin
          if (rem_q >= {3'b000, len_q}) begin
            rem_d  = rem_q - {3'b000, len_q};
            quot_d = quot_q + 3'd1;
          end else begin
            state_d = IDLE;
            if (quot_q == 3'd0) begin
              error_d = ERR_ZERO_BALLS;
            end else begin
              for (int k = 0; k < MAX_PERIOD; k++) begin
                pattern_d[k] = digit_buf_q[mod_small(4'(k), len_q)];
              end
              period_d = len_q;
              balls_d  = quot_q;
              valid_d  = 1'b1;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      len_q    <= 3'd0;
      ovf_q    <= 1'b0;
      idx_q    <= 3'd0;
      sum_q    <= 6'd0;
      mask_q   <= '0;
      rem_q    <= 6'd0;
      quot_q   <= 3'd0;
      error_q  <= ERR_NONE;
      for (int k = 0; k < MAX_PERIOD; k++) begin
        digit_buf_q[k] <= '0;
        pattern_q[k]   <= RESET_DIGIT;
      end
      period_q <= RESET_PERIOD;
      balls_q  <= RESET_BALLS;
      valid_q  <= 1'b0;
`ifdef SITESWAP_DEFAULT_EN
      boot_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      digit_buf_q <= digit_buf_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      mask_q      <= mask_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      error_q     <= error_d;
      pattern_q   <= pattern_d;
      period_q    <= period_d;
      balls_q     <= balls_d;
`ifdef SITESWAP_DEFAULT_EN
      valid_q     <= valid_d | boot_q;
      boot_q      <= 1'b0;
`else
      valid_q     <= valid_d;
`endif
    end
  end

  assign bus.pattern_out       = pattern_q;
  assign bus.period_out        = period_q;
  assign bus.num_balls_out     = balls_q;
  assign bus.pattern_valid_out = valid_q;
  assign bus.error_out         = error_q;
  assign bus.busy_out          = (state_q != IDLE);

endmodule

// File: tb/tb_siteswap_validator.sv
// Self-checking bench for siteswap_validator: a pattern-level model predicts
// the outcome and timing of each commit from the juggling rules, a compare
// process checks every output on every cycle, and directed scenarios pin a
// few literal values.
module tb_siteswap_validator;
  import juggle_pkg::*;

`ifdef SITESWAP_DEFAULT_EN
  localparam int RST_DIGIT  = 3;
  localparam int RST_PERIOD = 1;
  localparam int RST_BALLS  = 3;
  localparam int RST_PACKED = 32'o3333333;
`else
  localparam int RST_DIGIT  = 0;
  localparam int RST_PERIOD = 0;
  localparam int RST_BALLS  = 0;
  localparam int RST_PACKED = 0;
`endif

  logic clk_in = 1'b0;
  logic rst_in;

  siteswap_validator_if bus();

  siteswap_validator dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int compared   = 0;
  int mismatched = 0;

  // Model state: buffered digits, sticky error, outstanding check countdown.
  int m_digits[$];
  bit m_ovf;
  int m_err;
  int m_countdown;
  int m_pend_err;
  bit m_pend_ok;
  int m_pend_pat[7];
  int m_pend_period;
  int m_pend_balls;
  int m_pat[7];
  int m_period;
  int m_balls;
  bit m_valid;
  bit m_ready = 1'b0;
  bit m_boot;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int packDut();
    int p = 0;
    for (int k = 0; k < MAX_PERIOD; k++) p = p * 8 + int'(bus.pattern_out[k]);
    return p;
  endfunction

  function automatic int packModel();
    int p = 0;
    for (int k = 0; k < MAX_PERIOD; k++) p = p * 8 + m_pat[k];
    return p;
  endfunction

  task automatic modelReset();
    m_digits.delete();
    m_ovf       = 1'b0;
    m_err       = 0;
    m_countdown = 0;
    m_pend_ok   = 1'b0;
    m_pend_err  = 0;
    for (int k = 0; k < MAX_PERIOD; k++) m_pat[k] = RST_DIGIT;
    m_period = RST_PERIOD;
    m_balls  = RST_BALLS;
    m_valid  = 1'b0;
`ifdef SITESWAP_DEFAULT_EN
    m_boot   = 1'b1;
`else
    m_boot   = 1'b0;
`endif
  endtask

  // Decide the outcome of a commit from the siteswap rules and how many
  // cycles the sequential check needs before the result shows.
  task automatic modelCommit();
    int n, sum, coll, l;
    int hit[7];
    n     = m_digits.size();
    m_err = 0;
    if (n == 0) begin
      m_err = 1;
    end else if (m_ovf) begin
      m_err = 3;
    end else begin
      sum  = 0;
      coll = -1;
      for (int i = 0; i < 7; i++) hit[i] = 0;
      for (int i = 0; i < n; i++) begin
        l = (i + m_digits[i]) % n;
        if (coll < 0) begin
          if (hit[l] != 0) coll = i;
          else begin
            hit[l] = 1;
            sum += m_digits[i];
          end
        end
      end
      m_pend_ok = 1'b0;
      if (coll >= 0) begin
        m_countdown = coll + 1;
        m_pend_err  = 2;
      end else if (sum / n == 0) begin
        m_countdown = n + 1;
        m_pend_err  = 4;
      end else begin
        m_countdown   = n + sum / n + 1;
        m_pend_err    = 0;
        m_pend_ok     = 1'b1;
        m_pend_period = n;
        m_pend_balls  = sum / n;
        for (int k = 0; k < MAX_PERIOD; k++) m_pend_pat[k] = m_digits[k % n];
      end
    end
  endtask

  // Model update on each active edge, reading the same inputs the DUT samples.
  always @(posedge clk_in) begin
    if (rst_in) begin
      modelReset();
      m_ready = 1'b1;
    end else begin
      m_valid = m_boot;
      m_boot  = 1'b0;
      if (bus.clear_in) begin
        m_digits.delete();
        m_ovf       = 1'b0;
        m_err       = 0;
        m_countdown = 0;
      end else if (m_countdown > 0) begin
        m_countdown--;
        if (m_countdown == 0) begin
          m_err = m_pend_err;
          if (m_pend_ok) begin
            for (int k = 0; k < MAX_PERIOD; k++) m_pat[k] = m_pend_pat[k];
            m_period = m_pend_period;
            m_balls  = m_pend_balls;
            m_valid  = 1'b1;
          end
        end
      end else if (bus.commit_in) begin
        modelCommit();
      end else if (bus.digit_valid_in) begin
        if (m_digits.size() < MAX_PERIOD) m_digits.push_back(int'(bus.digit_in));
        else m_ovf = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk_in) begin
    if (m_ready) begin
      checkOutput("pattern_valid", int'(bus.pattern_valid_out), int'(m_valid));
      checkOutput("busy",          int'(bus.busy_out), int'(m_countdown > 0));
      checkOutput("error",         int'(bus.error_out), m_err);
      checkOutput("period",        int'(bus.period_out), m_period);
      checkOutput("num_balls",     int'(bus.num_balls_out), m_balls);
      checkOutput("pattern",       packDut(), packModel());
    end
  end

  task automatic applyStimulus(input logic [2:0] d, input logic dv, input logic cm, input logic cl);
    bus.digit_in       = d;
    bus.digit_valid_in = dv;
    bus.commit_in      = cm;
    bus.clear_in       = cl;
    @(negedge clk_in);
    bus.digit_in       = '0;
    bus.digit_valid_in = 1'b0;
    bus.commit_in      = 1'b0;
    bus.clear_in       = 1'b0;
  endtask

  task automatic enterDigit(input logic [2:0] d);
    applyStimulus(d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic doCommit();
    applyStimulus(3'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic doClear();
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Cycles from the commit edge to the pulse; 0 means no pulse within bound.
  task automatic waitPulse(input string name, input int expLat);
    int lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_in);
      if (bus.pattern_valid_out) begin
        lat = c;
        break;
      end
    end
    checkOutput(name, lat, expLat);
  endtask

  // Directed scenarios.
  initial begin
    rst_in             = 1'b1;
    bus.digit_in       = '0;
    bus.digit_valid_in = 1'b0;
    bus.commit_in      = 1'b0;
    bus.clear_in       = 1'b0;
    idleCycles(3);
    checkOutput("reset_period", int'(bus.period_out), RST_PERIOD);
    checkOutput("reset_balls",  int'(bus.num_balls_out), RST_BALLS);
    checkOutput("reset_pattern", packDut(), RST_PACKED);
    checkOutput("reset_error",  int'(bus.error_out), 0);
    checkOutput("reset_busy",   int'(bus.busy_out), 0);
    rst_in = 1'b0;
    idleCycles(2);

    $display("[TB] cascade 3");
    doClear();
    enterDigit(3'd3);
    doCommit();
    waitPulse("latency_3", 5);
    checkOutput("p3_period",  int'(bus.period_out), 1);
    checkOutput("p3_balls",   int'(bus.num_balls_out), 3);
    checkOutput("p3_pattern", packDut(), 32'o3333333);
    checkOutput("p3_error",   int'(bus.error_out), 0);

    $display("[TB] pattern 531");
    doClear();
    enterDigit(3'd5); enterDigit(3'd3); enterDigit(3'd1);
    doCommit();
    waitPulse("latency_531", 7);
    checkOutput("p531_period",  int'(bus.period_out), 3);
    checkOutput("p531_balls",   int'(bus.num_balls_out), 3);
    checkOutput("p531_pattern", packDut(), 32'o5315315);

    $display("[TB] collision 513");
    doClear();
    enterDigit(3'd5); enterDigit(3'd1); enterDigit(3'd3);
    doCommit();
    idleCycles(6);
    checkOutput("p513_error",   int'(bus.error_out), 2);
    checkOutput("p513_held",    packDut(), 32'o5315315);
    checkOutput("p513_period",  int'(bus.period_out), 3);

    $display("[TB] empty commit");
    doClear();
    doCommit();
    idleCycles(2);
    checkOutput("empty_error", int'(bus.error_out), 1);

    $display("[TB] seven digits then overflow");
    doClear();
    repeat (7) enterDigit(3'd3);
    doCommit();
    waitPulse("latency_7x3", 11);
    checkOutput("p7_period", int'(bus.period_out), 7);
    enterDigit(3'd3);
    doCommit();
    idleCycles(2);
    checkOutput("ovf_error",  int'(bus.error_out), 3);
    checkOutput("ovf_period", int'(bus.period_out), 7);

    $display("[TB] zero balls");
    doClear();
    enterDigit(3'd0);
    doCommit();
    idleCycles(4);
    checkOutput("zero_error",  int'(bus.error_out), 4);
    checkOutput("zero_period", int'(bus.period_out), 7);

    $display("[TB] commit beats digit, then re-commit");
    doClear();
    enterDigit(3'd3);
    applyStimulus(3'd5, 1'b1, 1'b1, 1'b0);
    waitPulse("latency_prio", 5);
    checkOutput("prio_period", int'(bus.period_out), 1);
    doCommit();
    waitPulse("latency_recommit", 5);
    checkOutput("recommit_balls", int'(bus.num_balls_out), 3);

    $display("[TB] clear during check");
    doClear();
    enterDigit(3'd7); enterDigit(3'd5); enterDigit(3'd3); enterDigit(3'd1);
    doCommit();
    idleCycles(1);
    doClear();
    checkOutput("clr_busy",  int'(bus.busy_out), 0);
    checkOutput("clr_error", int'(bus.error_out), 0);
    idleCycles(8);
    checkOutput("clr_held",  packDut(), 32'o3333333);
    doCommit();
    idleCycles(2);
    checkOutput("clr_len_zero", int'(bus.error_out), 1);

    $display("[TB] reset during divide");
    doClear();
    enterDigit(3'd4); enterDigit(3'd4); enterDigit(3'd1);
    doCommit();
    idleCycles(4);
    rst_in = 1'b1;
    idleCycles(2);
    rst_in = 1'b0;
    idleCycles(12);
    checkOutput("rst_div_period",  int'(bus.period_out), RST_PERIOD);
    checkOutput("rst_div_pattern", packDut(), RST_PACKED);
    checkOutput("rst_div_error",   int'(bus.error_out), 0);

    $display("[TB] pattern 441 after reset");
    enterDigit(3'd4); enterDigit(3'd4); enterDigit(3'd1);
    doCommit();
    waitPulse("latency_441", 7);
    checkOutput("p441_pattern", packDut(), 32'o4414414);
    checkOutput("p441_balls",   int'(bus.num_balls_out), 3);
    idleCycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/siteswap_validator.md
Name: siteswap_validator

Overview:
- Upstream stage of trajectory_generator. Collects siteswap digits entered one per strobe from the UI/button debouncer.
- On commit, sequentially checks that the siteswap is juggleable and computes the ball count.
- On success, publishes the 7-slot pattern, period and num_balls with a one-cycle pattern_valid pulse. Last good pattern is held through later errors so the animation keeps running.

Parameters:
- MAX_PERIOD, 7, max digits per pattern; fixed to the trajectory_generator array depth.
- DIGIT_W, 3, bits per throw digit (throws 0..7).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- digit_in  input  DIGIT_W  throw value to append
- digit_valid_in  input  1  append strobe, one digit per high cycle
- clear_in  input  1  discard entry buffer; abort any check
- commit_in  input  1  start validation of buffered digits
- pattern_out  output  DIGIT_W x MAX_PERIOD (unpacked [6:0])  validated pattern, periodically extended
- period_out  output  3  validated pattern length
- num_balls_out  output  3  sum/period
- pattern_valid_out  output  1  one-cycle pulse when new outputs take effect
- error_out  output  3  0 none, 1 EMPTY, 2 COLLISION, 3 OVERFLOW, 4 ZERO_BALLS; sticky until next commit/clear
- busy_out  output  1  high in CHECK and DIV

Behaviour:
- Reset: all outputs 0, buffer empty, len=0, ovf=0, state IDLE. Reset mid-CHECK/DIV aborts and emits no pulse.
- IDLE, digit_valid_in: if len<7, buf[len]<=digit_in, len++. Else ovf<=1 and the digit is dropped.
- IDLE, commit_in: error_out<=0. Outcomes:
  - len==0: error 1, stay IDLE.
  - ovf: error 3, stay IDLE.
  - otherwise: i=0, sum=0, mask=0, go to CHECK.
- commit_in has priority over digit_valid_in when both are high in the same cycle; the digit is dropped.
- clear_in has priority over everything except rst_in. It clears len, ovf and error_out, returns to IDLE from any state, and leaves the outputs untouched.
- In CHECK or DIV, digit_valid_in and commit_in are ignored.
- CHECK, one digit per cycle:
  - land = (i + buf[i]) mod len; sum += buf[i]; width 6 bits.
  - If mask[land] is already set: error 2, go to IDLE, no pulse.
  - Otherwise set mask[land]. After i = len-1, rem<=sum, q<=0, go to DIV.
- DIV, each cycle:
  - If rem >= len: rem -= len, q++.
  - Otherwise, on this edge: if q==0, error 4, no pulse.
  - Else register the outputs: pattern_out[k] = buf[k mod len] for k=0..6, period_out=len, num_balls_out=q. Assert pattern_valid_out for exactly this one following cycle, then go to IDLE.
- Latency: pulse is high exactly len + num_balls + 1 cycles after the edge that samples commit_in.
- Buffer is retained after commit; re-commit revalidates the same digits.
- Outputs change only on the pulse edge and are otherwise stable.

Optional Feature:
- Macro SITESWAP_DEFAULT_EN.
- Defined: reset loads pattern_out all 3, period_out=1, num_balls_out=3. pattern_valid_out pulses once on the first cycle after rst_in deasserts, so the display animates the cascade without UI input.
- Undefined: outputs reset to 0 and no pulse occurs until the first successful commit.

Decomposition:
- juggle_pkg holds: MAX_PERIOD, DIGIT_W, the error code enum (ERR_NONE..ERR_ZERO_BALLS), the state enum (IDLE, CHECK, DIV), and a pure function mod_small(a[3:0], n[2:0]) used for the landing index and the periodic fill.
- No sub-module. A single FSM module; trajectory_generator imports the same package constants.

Test Plan:
- Digits 3, commit -> pulse 5 cycles after commit; pattern all 3, period 1, balls 3, error 0.
- Digits 5,3,1, commit -> pulse after 7 cycles; pattern 5,3,1,5,3,1,5, period 3, balls 3.
- Digits 5,1,3, commit -> landing collision at i=1 (slot 2); error 2, no pulse, prior 5,3,1 outputs held.
- Commit with empty buffer -> error 1. 8 digits then commit -> error 3. Digit 0 then commit -> error 4. No pulse in any of these cases.
- Digits 7,5,3,1 committed, clear_in in the 2nd CHECK cycle -> IDLE, busy 0, no pulse, error 0, len 0.
- rst_in high during DIV of 4,4,1 -> outputs 0 (or the cascade under SITESWAP_DEFAULT_EN), no stale pulse.
